lsu_ctrl: RTL and testbench

Load/store unit controller between the pipeline memory stage and a word-organised data memory with a request/grant and read-valid handshake. It accepts one access at a time, checks alignment, and builds the word address, byte enables and replicated store data. For loads it shifts the returned word by the byte offset and sign/zero-extends it per the load-type code, then reports completion with a one-cycle done pulse. A watchdog bounds the wait for read data.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/ld_format.sv | 28 ++
 rtl/lsu_ctrl.sv | 144 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access codes, FSM states
// and the alignment rule applied when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Undefined load codes fall back to word alignment; the reserved store size always faults.
    function automatic logic misaligned(input logic we, input logic [2:0] memsel,
                                        input logic [1:0] stsel, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (stsel)
                ST_SW:   bad = (off != 2'b00);
                ST_SH:   bad = off[0];
                ST_SB:   bad = 1'b0;
                default: bad = 1'b1;
            endcase
        end else begin
            case (memsel)
                LD_LH, LD_LHU: bad = off[0];
                LD_LB, LD_LBU: bad = 1'b0;
                default:       bad = (off != 2'b00);
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/ld_format.sv
// Load formatter: shifts the returned word down by the byte offset and
// sign/zero-extends it according to the load code. Purely combinational.
module ld_format
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  Memsel,
    output logic [31:0] result
);

    logic [31:0] sh;

    assign sh = mem_rdata >> {off, 3'b000};

    always_comb begin
        result = '0;
        case (Memsel)
            LD_LW:   result = sh;
            LD_LH:   result = {{16{sh[15]}}, sh[15:0]};
            LD_LHU:  result = {16'h0000, sh[15:0]};
            LD_LB:   result = {{24{sh[7]}}, sh[7:0]};
            LD_LBU:  result = {24'h000000, sh[7:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: captures a request, checks alignment,
// drives a req/gnt memory port and formats load data; watchdog bounds the read wait.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         we,
    input  logic [2:0]   Memsel,
    input  logic [1:0]   Stsel,
    input  logic [31:0]  addr,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rdata,
    output logic         fault,
    output logic         bus_err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [3:0]   mem_be,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_gnt,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   rdata_q, rdata_d;
    logic           berr_q, berr_d;
    logic           we_q;
    logic [2:0]     memsel_q;
    logic [1:0]     stsel_q;
    logic [31:0]    addr_q;
    logic [N-1:0]   wdata_q;
    logic           capture_en;
    logic [31:0]    fmt_data;

    ld_format u_ld_format (
        .mem_rdata (mem_rdata),
        .off       (addr_q[1:0]),
        .Memsel    (memsel_q),
        .result    (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            berr_q   <= 1'b0;
            we_q     <= 1'b0;
            memsel_q <= '0;
            stsel_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            berr_q  <= berr_d;
            if (capture_en) begin
                we_q     <= we;
                memsel_q <= Memsel;
                stsel_q  <= Stsel;
                addr_q   <= addr;
                wdata_q  <= wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        rdata_d    = rdata_q;
        berr_d     = berr_q;
        capture_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                berr_d = 1'b0;
                if (start) begin
                    capture_en = 1'b1;
                    state_d    = misaligned(we, Memsel, Stsel, addr[1:0]) ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // rvalid on the final watchdog cycle still counts as a good load.
                if (mem_rvalid) begin
                    rdata_d = fmt_data;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_be    = 4'b1111;
        mem_wdata = wdata_q;
        if (we_q) begin
            case (stsel_q)
                ST_SH: begin
                    mem_be    = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                ST_SB: begin
                    mem_be    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE) || (state_q == S_ERR);
    assign fault    = (state_q == S_ERR);
    assign bus_err  = (state_q == S_DONE) && berr_q;
    assign mem_req  = (state_q == S_REQ);
    assign mem_we   = (state_q == S_REQ) && we_q;
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized accesses against a behavioural model of the load/store controller.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [2:0]  Memsel;
    logic [1:0]  Stsel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rdata = 32'h0;

    lsu_ctrl #(.N(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .we         (we),
        .Memsel     (Memsel),
        .Stsel      (Stsel),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .fault      (fault),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 marks the reserved store size.
    function automatic int unsigned m_size(input logic w, input logic [2:0] ms, input logic [1:0] ss);
        if (w) return (ss == 2'd0) ? 4 : (ss == 2'd1) ? 2 : (ss == 2'd2) ? 1 : 0;
        if (ms == 3'd1 || ms == 3'd3) return 2;
        if (ms == 3'd2 || ms == 3'd4) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] ms, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] sh;
        int v;
        sh = word >> (8 * a[1:0]);
        case (ms)
            3'd0: return sh;
            3'd1: begin v = int'(sh % 65536); if (v >= 32768) v -= 65536; return 32'(v); end
            3'd2: begin v = int'(sh % 256); if (v >= 128) v -= 256; return 32'(v); end
            3'd3: return sh % 65536;
            3'd4: return sh % 256;
            default: return 32'd0;
        endcase
    endfunction

    // rdly < 0 means the read data never arrives.
    task automatic do_access(input logic w, input logic [2:0] ms, input logic [1:0] ss,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int gdly, input int rdly, input logic [31:0] word);
        int unsigned sz;
        logic        flt;
        int          exp_lat, cyc, req_cycles, waitc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic        granted, done_seen, busy_ok, stable_ok;
        logic [68:0] snap;

        sz  = m_size(w, ms, ss);
        flt = (sz == 0) || ((a % sz) != 0);
        if (flt)          exp_lat = 1;
        else if (w)       exp_lat = gdly + 2;
        else if (rdly < 0) exp_lat = gdly + 2 + TO;
        else              exp_lat = gdly + rdly + 3;
        exp_be = (!w || sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << a[1:0]);
        exp_wd = (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 :
                 (sz == 1) ? (wd & 32'hFF) * 32'h01010101 : wd;

        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        start = 1'b1; we = w; Memsel = ms; Stsel = ss; addr = a; wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        cyc = 0; req_cycles = 0; waitc = 0; granted = 0;
        done_seen = 0; busy_ok = 1; stable_ok = 1; snap = '0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            addr = $urandom; wdata = $urandom; Memsel = 3'($urandom_range(0, 7));
            mem_rdata = $urandom;
            if (done) begin
                done_seen = 1;
            end else begin
                if (!busy) busy_ok = 0;
                if (mem_req) begin
                    req_cycles++;
                    if (req_cycles == 1) begin
                        snap = {mem_addr, mem_be, mem_wdata, mem_we};
                        chk("req_addr", mem_addr, {a[31:2], 2'b00});
                        chk("req_we", mem_we, w);
                        chk("req_be", mem_be, exp_be);
                        if (w) chk("req_wdata", mem_wdata, exp_wd);
                    end else if (snap !== {mem_addr, mem_be, mem_wdata, mem_we}) begin
                        stable_ok = 0;
                    end
                    mem_rvalid = 1'($urandom_range(0, 1));
                    if (req_cycles == gdly + 1) begin
                        mem_gnt = 1'b1;
                        granted = 1;
                    end
                end else if (granted) begin
                    waitc++;
                    if (rdly >= 0 && waitc == rdly + 1) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = word;
                    end
                end
            end
        end

        if (!flt && !w) exp_rdata = (rdly < 0) ? 32'h0 : m_load(ms, a, word);
        chk("done_seen", done_seen, 1);
        chk("latency", cyc, exp_lat);
        chk("fault", fault, flt);
        chk("bus_err", bus_err, !flt && !w && rdly < 0);
        chk("rdata", rdata, exp_rdata);
        chk("req_cycles", req_cycles, flt ? 0 : gdly + 1);
        chk("busy_during", busy_ok, 1);
        if (req_cycles > 1) chk("req_stable", stable_ok, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; Memsel = 3'd0; Stsel = 2'd0;
        addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;

        do_access(1'b0, 3'd2, 2'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);
        do_access(1'b0, 3'd3, 2'd0, 32'h202, 32'h0, 3, 0, 32'hBEEF_0000);
        do_access(1'b1, 3'd0, 2'd1, 32'h12, 32'h0000_ABCD, 0, 0, 32'h0);
        do_access(1'b0, 3'd0, 2'd0, 32'h101, 32'h0, 0, 0, 32'h1111_1111);
        do_access(1'b1, 3'd0, 2'd3, 32'h20, 32'h1234_5678, 0, 0, 32'h0);
        do_access(1'b0, 3'd0, 2'd0, 32'h300, 32'h0, 1, -1, 32'h5555_5555);
        do_access(1'b0, 3'd1, 2'd0, 32'h306, 32'h0, 0, 2, 32'h8001_7FFF);

        // Reset while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        start = 1'b1; we = 1'b0; Memsel = 3'd0; Stsel = 2'd0; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        chk("rw_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rw_in_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_busy", busy, 0);
        chk("rw_mem_req", mem_req, 0);
        chk("rw_rdata", rdata, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rw_no_done", done, 0);
        chk("rw_rdata_late", rdata, 0);
        exp_rdata = 32'h0;
        do_access(1'b0, 3'd0, 2'd0, 32'h44, 32'h0, 0, 0, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            logic        rw;
            logic [2:0]  rms;
            logic [1:0]  rss;
            int          rd;
            rw  = 1'($urandom_range(0, 1));
            rms = 3'($urandom_range(0, 7));
            rss = 2'($urandom_range(0, 3));
            rd  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            do_access(rw, rms, rss, $urandom, $urandom, int'($urandom_range(0, 3)), rd, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
